uart_cmd_latch: RTL and testbench

UART_CMD_LATCH -- requirements
Module: uart_cmd_latch

---
 rtl/uart_cmd_latch.sv | 116 +++++++++++
 tb/tb_uart_cmd_latch.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_latch.sv
// Latches UART command bytes into held game actions with a hold timeout.
// i_valid crosses in through a synchronizer; i_data is sampled on its synchronized rising edge.
module uart_cmd_latch #(
   parameter int HOLD_CYCLES = 3_600_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_right,
   output logic       o_left,
   output logic       o_squat,
   output logic       o_defend,
   output logic       o_jump,
   output logic       o_attack,
   output logic       o_select,
   output logic [7:0] o_err_cnt,
   output logic       o_active
);

   localparam int CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_reg, sync_next;
   logic [SYNC_STAGES-1:0] fill_reg;
   logic                   sv_prev_reg;
   logic                   armed_reg;
   logic [7:0]             byte_reg, byte_next;
   logic [6:0]             held_reg, held_next;
   logic [2:0]             held_prev_reg;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [7:0]             err_reg, err_next;
   logic                   sv, filled, rise, reject, accept;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign sync_next[gi] = i_valid;
         end else begin : g_rest
            assign sync_next[gi] = sync_reg[gi-1];
         end
      end
   endgenerate

   assign sv     = sync_reg[SYNC_STAGES-1];
   assign filled = fill_reg[SYNC_STAGES-1];
   // Edges only count once the chain holds real samples and a low level has been seen,
   // so a valid already high at reset release is ignored.
   assign rise   = armed_reg & sv & ~sv_prev_reg;

   assign byte_next = rise ? i_data : byte_reg;
   assign reject    = byte_next[7] | (byte_next[0] & byte_next[1]);
   assign accept    = rise & ~reject;

   always_comb begin
      held_next = held_reg;
      cnt_next  = cnt_reg;
      err_next  = err_reg;
      if (accept) begin
         held_next = byte_next[6:0];
         cnt_next  = CNT_LOAD;
      end else if (cnt_reg != '0) begin
         cnt_next = cnt_reg - CNT_W'(1);
      end else begin
         held_next = '0;
      end
      if (rise && reject && (err_reg != 8'hFF)) begin
         err_next = err_reg + 8'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sync_reg      <= '0;
         fill_reg      <= '0;
         sv_prev_reg   <= 1'b0;
         armed_reg     <= 1'b0;
         byte_reg      <= '0;
         held_reg      <= '0;
         held_prev_reg <= '0;
         cnt_reg       <= '0;
         err_reg       <= '0;
         o_right       <= 1'b0;
         o_left        <= 1'b0;
         o_squat       <= 1'b0;
         o_defend      <= 1'b0;
         o_jump        <= 1'b0;
         o_attack      <= 1'b0;
         o_select      <= 1'b0;
         o_active      <= 1'b0;
      end else begin
         sync_reg      <= sync_next;
         fill_reg      <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
         sv_prev_reg   <= sv;
         armed_reg     <= armed_reg | (filled & ~sv);
         byte_reg      <= byte_next;
         held_reg      <= held_next;
         held_prev_reg <= {held_reg[6], held_reg[4], held_reg[2]};
         cnt_reg       <= cnt_next;
         err_reg       <= err_next;
         o_right       <= held_reg[0];
         o_left        <= held_reg[1];
         o_squat       <= held_reg[3];
         o_defend      <= held_reg[5];
         o_jump        <= held_reg[2] & ~held_prev_reg[0];
         o_attack      <= held_reg[4] & ~held_prev_reg[1];
         o_select      <= held_reg[6] & ~held_prev_reg[2];
         o_active      <= (cnt_reg != '0);
      end
   end

   assign o_err_cnt = err_reg;

endmodule

// File: tb/tb_uart_cmd_latch.sv
// Scoreboard bench for uart_cmd_latch with a short hold so expiry paths are reachable.
module tb_uart_cmd_latch;

   localparam int S = 2;
   localparam int H = 16;

   logic       i_clk, i_rst_n, i_valid;
   logic [7:0] i_data;
   logic       o_right, o_left, o_squat, o_defend, o_jump, o_attack, o_select, o_active;
   logic [7:0] o_err_cnt;

   typedef struct {
      logic [3:0] lv;   // {defend, squat, left, right}
      logic [2:0] pu;   // {select, attack, jump}
      logic       act;
      logic [7:0] err;
   } exp_t;

   exp_t       sb[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] err_exp = 8'd0;
   int         right_hi = 0, act_hi = 0, jump_p = 0, sel_p = 0;

   uart_cmd_latch #(.HOLD_CYCLES(H), .SYNC_STAGES(S)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
      .o_right(o_right), .o_left(o_left), .o_squat(o_squat), .o_defend(o_defend),
      .o_jump(o_jump), .o_attack(o_attack), .o_select(o_select),
      .o_err_cnt(o_err_cnt), .o_active(o_active)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      if (o_right)  right_hi++;
      if (o_active) act_hi++;
      if (o_jump)   jump_p++;
      if (o_select) sel_p++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic [3:0] lv, input logic [2:0] pu,
                       input logic act);
      exp_t e, g;
      if (d[7] || (d[0] && d[1])) begin
         if (err_exp != 8'hFF) err_exp = err_exp + 8'd1;
      end
      e.lv = lv; e.pu = pu; e.act = act; e.err = err_exp;
      sb.push_back(e);
      @(negedge i_clk);
      i_data  = d;
      i_valid = 1'b1;
      repeat (S + 2) @(posedge i_clk);
      @(negedge i_clk);
      g = sb.pop_front();
      chk("levels", 32'({o_defend, o_squat, o_left, o_right}), 32'(g.lv));
      chk("pulses", 32'({o_select, o_attack, o_jump}), 32'(g.pu));
      chk("active", 32'(o_active), 32'(g.act));
      chk("err_cnt", 32'(o_err_cnt), 32'(g.err));
      $display("[TB] byte %02h levels=%b pulses=%b active=%b err=%0d", d,
               {o_defend, o_squat, o_left, o_right}, {o_select, o_attack, o_jump},
               o_active, o_err_cnt);
      i_valid = 1'b0;
      @(negedge i_clk);
      chk("pulse_width", 32'({o_select, o_attack, o_jump}), 32'(0));
      repeat (S + 1) @(negedge i_clk);
   endtask

   initial begin
      int r0, a0, j0, s0, sq, ac;
      i_rst_n = 1'b0; i_valid = 1'b0; i_data = 8'h00;
      repeat (3) @(negedge i_clk);
      chk("rst_levels", 32'({o_defend, o_squat, o_left, o_right}), 32'(0));
      chk("rst_pulses", 32'({o_select, o_attack, o_jump}), 32'(0));
      chk("rst_active", 32'(o_active), 32'(0));
      chk("rst_err", 32'(o_err_cnt), 32'(0));
      i_rst_n = 1'b1;
      repeat (5) @(negedge i_clk);

      // Single right press: held H cycles, active while counter non-zero (H-1)
      r0 = right_hi; a0 = act_hi;
      send(8'h01, 4'b0001, 3'b000, 1'b1);
      repeat (40) @(negedge i_clk);
      chk("right_len", 32'(right_hi - r0), 32'(H));
      chk("active_len", 32'(act_hi - a0), 32'(H - 1));
      chk("right_off", 32'(o_right), 32'(0));

      // Jump pulse, then repeat within hold: no new pulse, hold extended
      j0 = jump_p;
      send(8'h04, 4'b0000, 3'b001, 1'b1);
      send(8'h04, 4'b0000, 3'b000, 1'b1);
      repeat (6) @(negedge i_clk);
      chk("hold_extended", 32'(o_active), 32'(1));
      chk("jump_count", 32'(jump_p - j0), 32'(1));
      repeat (40) @(negedge i_clk);

      // Rejected bytes and saturation
      send(8'h83, 4'b0000, 3'b000, 1'b0);
      send(8'h03, 4'b0000, 3'b000, 1'b0);
      chk("err_two", 32'(o_err_cnt), 32'(2));
      for (int i = 0; i < 298; i++) begin
         send(8'h80 | 8'(i & 127), 4'b0000, 3'b000, 1'b0);
      end
      chk("err_sat", 32'(o_err_cnt), 32'(255));

      // Acceptance on the expiry cycle: defend hands over to squat with no gap
      @(negedge i_clk);
      i_data = 8'h20; i_valid = 1'b1;
      sq = 0; ac = 0;
      for (int k = 1; k <= 45; k++) begin
         @(posedge i_clk);
         @(negedge i_clk);
         if (k == 3) i_valid = 1'b0;
         if (k == 16) begin i_data = 8'h08; i_valid = 1'b1; end
         if (k == 19) i_valid = 1'b0;
         if (k >= 4 && k <= 20) chk("no_gap", 32'(o_defend | o_squat), 32'(1));
         if (k == 19) chk("defend_last", 32'({o_defend, o_squat}), 32'(2'b10));
         if (k == 20) begin
            chk("squat_first", 32'({o_defend, o_squat}), 32'(2'b01));
            chk("active_reload", 32'(o_active), 32'(1));
         end
         if (k >= 20) begin
            if (o_squat) sq++;
            if (o_active) ac++;
         end
      end
      $display("[TB] expiry handover squat=%0d active=%0d", sq, ac);
      chk("squat_len", 32'(sq), 32'(H));
      chk("reload_len", 32'(ac), 32'(H - 1));

      // Long valid: exactly one select pulse
      s0 = sel_p;
      @(negedge i_clk);
      i_data = 8'h40; i_valid = 1'b1;
      repeat (1000) @(negedge i_clk);
      i_valid = 1'b0;
      repeat (30) @(negedge i_clk);
      $display("[TB] long valid select pulses=%0d", sel_p - s0);
      chk("select_once", 32'(sel_p - s0), 32'(1));

      // Reset mid-hold, release with valid high
      send(8'h02, 4'b0010, 3'b000, 1'b1);
      chk("left_before_rst", 32'(o_left), 32'(1));
      @(negedge i_clk);
      i_rst_n = 1'b0; i_data = 8'h01; i_valid = 1'b1;
      @(negedge i_clk);
      chk("rst_mid_levels", 32'({o_defend, o_squat, o_left, o_right}), 32'(0));
      chk("rst_mid_active", 32'(o_active), 32'(0));
      chk("rst_mid_err", 32'(o_err_cnt), 32'(0));
      err_exp = 8'd0;
      i_rst_n = 1'b1;
      repeat (20) @(negedge i_clk);
      chk("no_byte_after_rst", 32'({o_right, o_active}), 32'(0));
      i_valid = 1'b0;
      repeat (4) @(negedge i_clk);
      send(8'h01, 4'b0001, 3'b000, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
